// File: rtl/csr_file_if.sv
// CSR file bus: decode read port, execute/exception write ports, and exported state.
interface csr_file_if;
    logic [11:0] raddr_i;
    logic [31:0] rdata_o;
    logic        we_i;
    logic [11:0] waddr_i;
    logic [31:0] wdata_i;
    logic        excp_we_i;
    logic [11:0] excp_waddr_i;
    logic [31:0] excp_wdata_i;
    logic        timer_irq_i;
    logic [31:0] csr_mtvec_o;
    logic [31:0] csr_mepc_o;
    logic [31:0] csr_mstatus_o;
    logic        irq_pending_o;

    modport master (
        output raddr_i, we_i, waddr_i, wdata_i,
        output excp_we_i, excp_waddr_i, excp_wdata_i, timer_irq_i,
        input  rdata_o, csr_mtvec_o, csr_mepc_o, csr_mstatus_o, irq_pending_o
    );

    modport slave (
        input  raddr_i, we_i, waddr_i, wdata_i,
        input  excp_we_i, excp_waddr_i, excp_wdata_i, timer_irq_i,
        output rdata_o, csr_mtvec_o, csr_mepc_o, csr_mstatus_o, irq_pending_o
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read, dual write ports (exception port wins), 64-bit mcycle.
module csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    csr_file_if.slave  bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 12;
    localparam int unsigned NW   = 8;

    localparam int unsigned IDX_MSTATUS  = 0;
    localparam int unsigned IDX_MIE      = 1;
    localparam int unsigned IDX_MTVEC    = 2;
    localparam int unsigned IDX_MSCRATCH = 3;
    localparam int unsigned IDX_MEPC     = 4;
    localparam int unsigned IDX_MCAUSE   = 5;
    localparam int unsigned IDX_MCYCLE   = 6;
    localparam int unsigned IDX_MCYCLEH  = 7;

    localparam logic [AW-1:0] W_ADDRS [NW] = '{
        12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80
    };

    logic            r_mstatus_mie;
    logic            r_mstatus_mpie;
    logic            r_mie_mtie;
    logic [XLEN-3:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-3:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [63:0]     r_mcycle;

    logic [NW-1:0]   w_we;
    logic [XLEN-1:0] w_wd [NW];
    logic [63:0]     w_mcycle_nxt;
    logic [XLEN-1:0] w_mstatus;

    // Per-CSR write decode; the exception port's data wins on an address collision.
    always_comb begin
        w_we = '0;
        for (int i = 0; i < int'(NW); i++) begin
            w_we[i] = (bus.excp_we_i && (bus.excp_waddr_i == W_ADDRS[i]))
                   || (bus.we_i && (bus.waddr_i == W_ADDRS[i]));
            w_wd[i] = (bus.excp_we_i && (bus.excp_waddr_i == W_ADDRS[i]))
                   ? bus.excp_wdata_i : bus.wdata_i;
        end
    end

    // A write to either half suppresses the increment for that cycle.
    always_comb begin
        w_mcycle_nxt = r_mcycle + 64'd1;
        if (w_we[IDX_MCYCLE] || w_we[IDX_MCYCLEH]) begin
            w_mcycle_nxt = r_mcycle;
            if (w_we[IDX_MCYCLE])  w_mcycle_nxt[31:0]  = w_wd[IDX_MCYCLE];
            if (w_we[IDX_MCYCLEH]) w_mcycle_nxt[63:32] = w_wd[IDX_MCYCLEH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie_mtie     <= 1'b0;
            r_mtvec        <= MTVEC_RESET[31:2];
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mcycle       <= '0;
        end else begin
            if (w_we[IDX_MSTATUS]) begin
                r_mstatus_mie  <= w_wd[IDX_MSTATUS][3];
                r_mstatus_mpie <= w_wd[IDX_MSTATUS][7];
            end
            if (w_we[IDX_MIE])      r_mie_mtie <= w_wd[IDX_MIE][7];
            if (w_we[IDX_MTVEC])    r_mtvec    <= w_wd[IDX_MTVEC][31:2];
            if (w_we[IDX_MSCRATCH]) r_mscratch <= w_wd[IDX_MSCRATCH];
            if (w_we[IDX_MEPC])     r_mepc     <= w_wd[IDX_MEPC][31:2];
            if (w_we[IDX_MCAUSE])   r_mcause   <= w_wd[IDX_MCAUSE];
            r_mcycle <= w_mcycle_nxt;
        end
    end

    // MPP is hardwired to machine mode.
    assign w_mstatus = {19'h0, 2'b11, 3'b000, r_mstatus_mpie, 3'b000, r_mstatus_mie, 3'b000};

    always_comb begin
        bus.rdata_o = '0;
        case (bus.raddr_i)
            12'h300: bus.rdata_o = w_mstatus;
            12'h304: bus.rdata_o = {24'h0, r_mie_mtie, 7'h0};
            12'h305: bus.rdata_o = {r_mtvec, 2'b00};
            12'h340: bus.rdata_o = r_mscratch;
            12'h341: bus.rdata_o = {r_mepc, 2'b00};
            12'h342: bus.rdata_o = r_mcause;
            12'h344: bus.rdata_o = {24'h0, bus.timer_irq_i, 7'h0};
            12'hB00, 12'hC00: bus.rdata_o = r_mcycle[31:0];
            12'hB80, 12'hC80: bus.rdata_o = r_mcycle[63:32];
            12'hF14: bus.rdata_o = HART_ID;
            default: bus.rdata_o = '0;
        endcase
    end

    assign bus.csr_mtvec_o   = {r_mtvec, 2'b00};
    assign bus.csr_mepc_o    = {r_mepc, 2'b00};
    assign bus.csr_mstatus_o = w_mstatus;
    assign bus.irq_pending_o = bus.timer_irq_i & r_mie_mtie;
endmodule

// File: tb/tb_csr_file.sv
// Directed scoreboard bench for csr_file: expectations queued at stimulus, popped at each check.
module tb_csr_file;
    logic clk;
    logic rst_n;
    csr_file_if bus();

    csr_file #(
        .MTVEC_RESET(32'h8000_0003),
        .HART_ID    (32'h0000_0007)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h expected <queued entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        push(tag, exp);
        bus.raddr_i = a;
        #1;
        check(bus.rdata_o);
    endtask

    task automatic port(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        push(tag, exp);
        check(obs);
    endtask

    task automatic exu(input logic [11:0] a, input logic [31:0] d);
        bus.we_i    = 1'b1;
        bus.waddr_i = a;
        bus.wdata_i = d;
    endtask

    task automatic excp(input logic [11:0] a, input logic [31:0] d);
        bus.excp_we_i    = 1'b1;
        bus.excp_waddr_i = a;
        bus.excp_wdata_i = d;
    endtask

    task automatic idle();
        bus.we_i      = 1'b0;
        bus.excp_we_i = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.raddr_i      = '0;
        bus.we_i         = 1'b0;
        bus.waddr_i      = '0;
        bus.wdata_i      = '0;
        bus.excp_we_i    = 1'b0;
        bus.excp_waddr_i = '0;
        bus.excp_wdata_i = '0;
        bus.timer_irq_i  = 1'b0;
        #12;

        // Reset state
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mtvec", 12'h305, 32'h8000_0000);
        port("rst_mstatus_o", bus.csr_mstatus_o, 32'h0000_1800);
        port("rst_mepc_o", bus.csr_mepc_o, 32'h0);
        port("rst_mtvec_o", bus.csr_mtvec_o, 32'h8000_0000);
        port("rst_irq", 32'(bus.irq_pending_o), 32'h0);
        rd("rst_mcycle", 12'hB00, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        step(); rd("cyc_1", 12'hB00, 32'd1);
        step(); rd("cyc_2", 12'hB00, 32'd2);
        step(); rd("cyc_3", 12'hB00, 32'd3);
        rd("hartid", 12'hF14, 32'h0000_0007);

        // Back-to-back trap-entry writes from the exception unit
        excp(12'h341, 32'h0000_0104);
        step(); port("trap_mepc_o", bus.csr_mepc_o, 32'h0000_0104);
        excp(12'h300, 32'h0000_1880);
        step(); port("trap_mstatus_o", bus.csr_mstatus_o, 32'h0000_1880);
        excp(12'h342, 32'h0000_000B);
        step(); idle();
        rd("trap_mcause", 12'h342, 32'h0000_000B);
        port("trap_mepc_hold", bus.csr_mepc_o, 32'h0000_0104);

        // Collision on one address, then parallel writes to different addresses
        exu(12'h341, 32'h200); excp(12'h341, 32'h300);
        step(); idle();
        port("coll_mepc", bus.csr_mepc_o, 32'h300);
        exu(12'h340, 32'h55); excp(12'h341, 32'h10);
        step(); idle();
        rd("par_mscratch", 12'h340, 32'h55);
        port("par_mepc", bus.csr_mepc_o, 32'h10);

        // Write masks, read-only and unimplemented addresses
        exu(12'h300, 32'hFFFF_FFFF);
        step(); idle();
        rd("mask_mstatus", 12'h300, 32'h0000_1888);
        exu(12'h341, 32'h123);
        step(); idle();
        rd("mask_mepc", 12'h341, 32'h120);
        exu(12'h305, 32'h1234_5677);
        step(); idle();
        port("mask_mtvec_o", bus.csr_mtvec_o, 32'h1234_5674);
        exu(12'h344, 32'hFFFF_FFFF);
        step(); idle();
        rd("ro_mip", 12'h344, 32'h0);
        rd("unimpl", 12'hABC, 32'h0);
        exu(12'h341, 32'h400);
        rd("no_bypass", 12'h341, 32'h120);
        step(); idle();
        rd("after_write", 12'h341, 32'h400);

        // Counter: read-only alias, carry, mcycleh write holding the low half
        exu(12'hB00, 32'd100);
        step(); idle();
        exu(12'hC00, 32'h0);
        step(); idle();
        rd("ro_cycle_alias", 12'hB00, 32'd101);
        exu(12'hB00, 32'hFFFF_FFFE);
        step(); idle();
        rd("cyc_lo_wr", 12'hB00, 32'hFFFF_FFFE);
        exu(12'hB80, 32'h0);
        step(); idle();
        rd("cyc_lo_hold", 12'hB00, 32'hFFFF_FFFE);
        step();
        rd("cyc_lo_ff", 12'hB00, 32'hFFFF_FFFF);
        rd("cyc_hi_0", 12'hB80, 32'h0);
        step();
        rd("cyc_lo_wrap", 12'hB00, 32'h0);
        rd("cyc_hi_carry", 12'hB80, 32'h1);
        rd("cycleh_alias", 12'hC80, 32'h1);
        exu(12'hB80, 32'd5);
        step(); idle();
        rd("cych_wr", 12'hB80, 32'd5);
        rd("cych_lo_hold", 12'hB00, 32'h0);
        exu(12'hB00, 32'hFFFF_FFFF); excp(12'hB80, 32'hFFFF_FFFF);
        step(); idle();
        rd("cyc_all_ones", 12'hC00, 32'hFFFF_FFFF);
        step();
        rd("cyc64_wrap_lo", 12'hB00, 32'h0);
        rd("cyc64_wrap_hi", 12'hB80, 32'h0);

        // Timer interrupt gating
        bus.timer_irq_i = 1'b1;
        #1;
        port("irq_masked", 32'(bus.irq_pending_o), 32'h0);
        rd("mip_pending", 12'h344, 32'h80);
        exu(12'h304, 32'hFFFF_FFFF);
        #1;
        port("irq_before_edge", 32'(bus.irq_pending_o), 32'h0);
        step(); idle();
        port("irq_enabled", 32'(bus.irq_pending_o), 32'h1);
        rd("mie_mask", 12'h304, 32'h80);

        // Asynchronous reset mid-operation
        #1;
        rst_n = 1'b0;
        #1;
        port("arst_irq", 32'(bus.irq_pending_o), 32'h0);
        port("arst_mepc_o", bus.csr_mepc_o, 32'h0);
        port("arst_mstatus_o", bus.csr_mstatus_o, 32'h0000_1800);
        port("arst_mtvec_o", bus.csr_mtvec_o, 32'h8000_0000);
        rd("arst_mcycle", 12'hB00, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        rd("arst_cyc_1", 12'hB00, 32'd1);

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drained: observed %0d entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode CSR register file for the single-hart core. Serves combinational CSR reads to the decode stage and accepts CSR writes from two sources, the execute unit (CSRRW/S/C results) and the exception unit (trap-entry and mret updates). It exports mtvec, mepc and mstatus to the exception unit and runs the 64-bit mcycle counter. The exception unit's write port always has priority over the execute unit's write port.

## Interface
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec; bits [1:0] are forced to 0.
- HART_ID, 32'h0, value returned by mhartid.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- raddr_i  in  12  CSR read address from the decode unit
- rdata_o  out  32  CSR read data, combinational from raddr_i
- we_i  in  1  execute-unit write enable
- waddr_i  in  12  execute-unit write address
- wdata_i  in  32  execute-unit write data (final value; read-modify-write is resolved upstream)
- excp_we_i  in  1  exception-unit write enable
- excp_waddr_i  in  12  exception-unit write address
- excp_wdata_i  in  32  exception-unit write data
- timer_irq_i  in  1  timer interrupt level from the CLINT
- csr_mtvec_o  out  32  current mtvec
- csr_mepc_o  out  32  current mepc
- csr_mstatus_o  out  32  current mstatus
- irq_pending_o  out  1  timer_irq_i & mie[7]

## Operation
- Implemented CSRs, with their write rules:
  - mstatus 0x300: bits 3 (MIE) and 7 (MPIE) are writable; bits [12:11] (MPP) read 2'b11; all other bits read 0.
  - mie 0x304: only bit 7 (MTIE) is writable.
  - mtvec 0x305: {wdata[31:2],2'b00}.
  - mscratch 0x340: full 32 bits.
  - mepc 0x341: {wdata[31:2],2'b00}.
  - mcause 0x342: full 32 bits.
  - mip 0x344: read-only; bit 7 = timer_irq_i, other bits 0.
  - mcycle 0xB00 / mcycleh 0xB80: read/write low/high halves of the counter.
  - cycle 0xC00 / cycleh 0xC80: read-only aliases of mcycle / mcycleh.
  - mhartid 0xF14: read-only, returns HART_ID.
- Unimplemented addresses read 32'h0. Writes to them, and to read-only CSRs, are ignored.
- Write arbitration:
  - Both ports write the same address in the same cycle: the excp port value is stored and the exu write is dropped.
  - The ports write different addresses: both writes take effect in the same cycle.
- mcycle:
  - Increments by 1 every cycle. The 64-bit value wraps 0xFFFF_FFFF_FFFF_FFFF to 0.
  - In a cycle that writes mcycle, the next value is {old[63:32], wdata}, with no increment.
  - In a cycle that writes mcycleh, the next value is {wdata, old[31:0]}, with no increment.
  - A carry out of the low half propagates into the high half.
- rdata_o has no write bypass. A read in the same cycle as a write to that address returns the old value.
- csr_*_o and irq_pending_o are driven directly from the registers (irq_pending_o also from timer_irq_i). A value written at edge N is visible on them after edge N.

## Timing
- Reset values:
  - mstatus 32'h0000_1800; mie 0; mtvec {MTVEC_RESET[31:2],2'b00}; mscratch 0; mepc 0; mcause 0; mcycle 0.
  - csr_mstatus_o = 32'h1800, csr_mepc_o = 0, csr_mtvec_o = MTVEC_RESET & ~3.
  - irq_pending_o = 0.
- Write latency is 1 cycle: data is sampled on the clk rising edge while the enable is high.
- Read latency is 0 cycles (combinational).
- mcycle reads 1 in the first cycle after reset deasserts; 0 is held while rst_n is low.
- Reset asserted mid-operation clears every register immediately (asynchronous), including the counter.
- The exception unit issues back-to-back single-cycle writes (mepc, mstatus, mcause). Each write must land on consecutive edges with no stall or lost write.

## Test plan
- Reset release: read 0x300 -> 32'h1800; read 0x305 with MTVEC_RESET=32'h8000_0003 -> 32'h8000_0000; read 0xB00 on successive cycles -> 1, 2, 3.
- Trap sequence: excp writes 0x341=32'h0000_0104, then 0x300=32'h0000_1880, then 0x342=32'h0000_000B on consecutive cycles -> csr_mepc_o=0x104, csr_mstatus_o=0x1880, mcause reads 0xB.
- Write collision: exu and excp both write 0x341 (exu 0x200, excp 0x300) -> mepc=0x300. Then exu writes 0x340=0x55 while excp writes 0x341=0x10 -> both stored.
- Masking: write 0x300=32'hFFFF_FFFF -> reads 32'h0000_1888. Write 0x341=0x123 -> reads 0x120. Write 0xC00 or 0x344 -> no change. Read 0xABC -> 0.
- Counter: write 0xB00=32'hFFFF_FFFE, 0xB80=0 -> low half reads 0xFFFF_FFFF, then 0x0 with mcycleh=1. Write mcycleh=5 -> high half=5 and low half holds that cycle.
- Interrupt: timer_irq_i=1, mie=0 -> irq_pending_o=0 and mip reads 0x80. Then write mie=0x80 -> irq_pending_o=1 from the next cycle.
